// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Instruction-decode pipeline stage: architectural register file with a
// same-cycle writeback bypass, load-use hazard detection, and the ID/EX
// pipeline register with valid/ready flow control and flush.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   id_valid_i / id_ready_o   IF/ID handshake
//   id_pc_i, id_instr_i       decode PC and raw instruction (register fields)
//   id_imm_i, id_ctrl_i       decoded immediate and opaque control bundle
//   id_mem_read_i, id_reg_write_i, id_uses_rs1_i, id_uses_rs2_i  decoder flags
//   wb_reg_write_en_i, wb_rd_addr_i, wb_result_i                writeback port
//   flush_i                   squash held and incoming instruction
//   ex_valid_o / ex_ready_i   ID/EX handshake
//   ex_*_o                    registered ID/EX payload
//   hazard_stall_o            combinational load-use stall indicator
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    parameter int  CTRL_W   = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [31:0]       id_instr_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_mem_read_i,
    input  logic              id_reg_write_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic              wb_reg_write_en_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_result_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_read_data1_o,
    output logic [XLEN-1:0]   ex_read_data2_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_mem_read_o,
    output logic              ex_reg_write_o,
    output logic [REG_AW-1:0] ex_rs1_addr_o,
    output logic [REG_AW-1:0] ex_rs2_addr_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic              hazard_stall_o
);

    logic [XLEN-1:0]   rf_q [NUM_REGS];

    logic [REG_AW-1:0] rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0]   rdata1_s, rdata2_s;
    logic              hazard_s, advance_s, load_s;
    logic              unused_instr_s;

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]   ex_rdata1_q, ex_rdata1_d;
    logic [XLEN-1:0]   ex_rdata2_q, ex_rdata2_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

    // Register specifiers, truncated to the architectural address width
    assign rs1_s = id_instr_i[15 +: REG_AW];
    assign rs2_s = id_instr_i[20 +: REG_AW];
    assign rd_s  = id_instr_i[7 +: REG_AW];
    // Opcode/funct bits are consumed by the upstream decoder, not here
    assign unused_instr_s = ^{id_instr_i[31:25], id_instr_i[14:12], id_instr_i[6:0]};

    // Register file storage; entry 0 is never written so it always reads zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_reg_write_en_i && (wb_rd_addr_i != '0)) begin
            rf_q[wb_rd_addr_i] <= wb_result_i;
        end
    end

    // Read ports with same-cycle writeback bypass
    always_comb begin
        rdata1_s = '0;
        rdata2_s = '0;
        if (rs1_s == '0) begin
            rdata1_s = '0;
        end else if (wb_reg_write_en_i && (wb_rd_addr_i == rs1_s)) begin
            rdata1_s = wb_result_i;
        end else begin
            rdata1_s = rf_q[rs1_s];
        end
        if (rs2_s == '0) begin
            rdata2_s = '0;
        end else if (wb_reg_write_en_i && (wb_rd_addr_i == rs2_s)) begin
            rdata2_s = wb_result_i;
        end else begin
            rdata2_s = rf_q[rs2_s];
        end
    end

    // Load-use hazard and flow-control decisions
    always_comb begin
        hazard_s  = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                    ((id_uses_rs1_i && (rs1_s == ex_rd_q)) ||
                     (id_uses_rs2_i && (rs2_s == ex_rd_q)));
        advance_s = !ex_valid_q || ex_ready_i;
        load_s    = advance_s && id_valid_i && !hazard_s;
    end

    assign id_ready_o     = flush_i || (advance_s && !hazard_s);
    assign hazard_stall_o = hazard_s && id_valid_i;

    // ID/EX next state: flush beats load, load beats bubble, otherwise hold
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_rdata1_d    = ex_rdata1_q;
        ex_rdata2_d    = ex_rdata2_q;
        ex_imm_d       = ex_imm_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (load_s) begin
            ex_valid_d     = 1'b1;
            ex_pc_d        = id_pc_i;
            ex_rdata1_d    = rdata1_s;
            ex_rdata2_d    = rdata2_s;
            ex_imm_d       = id_imm_i;
            ex_ctrl_d      = id_ctrl_i;
            ex_mem_read_d  = id_mem_read_i;
            ex_reg_write_d = id_reg_write_i;
            ex_rs1_d       = rs1_s;
            ex_rs2_d       = rs2_s;
            ex_rd_d        = rd_s;
        end else if (advance_s) begin
            // Bubble: payload left stale, only the valid bit drops
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_rdata1_q    <= '0;
            ex_rdata2_q    <= '0;
            ex_imm_q       <= '0;
            ex_ctrl_q      <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_rdata1_q    <= ex_rdata1_d;
            ex_rdata2_q    <= ex_rdata2_d;
            ex_imm_q       <= ex_imm_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign ex_pc_o         = ex_pc_q;
    assign ex_read_data1_o = ex_rdata1_q;
    assign ex_read_data2_o = ex_rdata2_q;
    assign ex_imm_o        = ex_imm_q;
    assign ex_ctrl_o       = ex_ctrl_q;
    assign ex_mem_read_o   = ex_mem_read_q;
    assign ex_reg_write_o  = ex_reg_write_q;
    assign ex_rs1_addr_o   = ex_rs1_q;
    assign ex_rs2_addr_o   = ex_rs2_q;
    assign ex_rd_addr_o    = ex_rd_q;

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, register and immediate values.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; REG_AW = clog2(NUM_REGS).
REQ-003 Parameter CTRL_W, default 16, width of the opaque control bundle from the decoder.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 id_valid_i / id_ready_o  in/out  1/1  IF/ID handshake; transfer when both high.
REQ-008 id_pc_i  in  XLEN; id_instr_i  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], truncated to REG_AW.
REQ-009 id_imm_i  in  XLEN; id_ctrl_i  in  CTRL_W  decoded bundle, passed through unmodified.
REQ-010 id_mem_read_i, id_reg_write_i, id_uses_rs1_i, id_uses_rs2_i  in  1 each  decoder flags.
REQ-011 wb_reg_write_en_i  in  1; wb_rd_addr_i  in  REG_AW; wb_result_i  in  XLEN  writeback port.
REQ-012 flush_i  in  1  squash held and incoming instruction.
REQ-013 ex_valid_o / ex_ready_i  out/in  1/1  ID/EX handshake.
REQ-014 ex_pc_o, ex_read_data1_o, ex_read_data2_o, ex_imm_o  out  XLEN; ex_ctrl_o  out  CTRL_W.
REQ-015 ex_mem_read_o, ex_reg_write_o  out  1; ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  REG_AW.
REQ-016 hazard_stall_o  out  1  load-use stall indicator, combinational.

Function
REQ-017 Register file: NUM_REGS x XLEN, two combinational read ports, one write port; register 0 SHALL read 0 and ignore writes.
REQ-018 Write SHALL occur at the clock edge when wb_reg_write_en_i=1 and wb_rd_addr_i!=0.
REQ-019 Same-cycle bypass: a read address equal to a nonzero wb_rd_addr_i with write enable SHALL return wb_result_i.
REQ-020 hazard = ex_valid_o & ex_mem_read_o & ex_rd_addr_o!=0 & ((id_uses_rs1_i & rs1==ex_rd_addr_o) | (id_uses_rs2_i & rs2==ex_rd_addr_o)); hazard_stall_o = hazard & id_valid_i.
REQ-021 advance = !ex_valid_o | ex_ready_i.
REQ-022 id_ready_o = flush_i | (advance & !hazard).
REQ-023 Priority per edge: flush_i, then load, then bubble, then hold.
REQ-024 flush_i=1: ex_valid_o SHALL be 0 next cycle; the incoming instruction is consumed and discarded.
REQ-025 Load (advance & id_valid_i & !hazard): all ex_* payload registers capture decode values; ex_valid_o=1 next cycle.
REQ-026 Bubble (advance & (!id_valid_i | hazard)): ex_valid_o=0 next cycle; payload MAY hold stale values.
REQ-027 Hold (!advance): all ex_* registers SHALL be stable while ex_valid_o=1 and ex_ready_i=0.
REQ-028 Latency: one cycle from ID transfer to ex_valid_o; full throughput of one instruction per cycle absent hazard or back-pressure.
REQ-029 Writeback during hold SHALL NOT update captured ex_read_data*_o; forwarding is the EX stage's responsibility.
REQ-030 Load-use stall SHALL last exactly one cycle when ex_ready_i=1.

Reset
REQ-031 rst_i=1 SHALL clear ex_valid_o, all ex_* outputs and all registers to 0 immediately, regardless of clock.
REQ-032 Reset asserted mid-stall SHALL drop the held instruction; after release, id_ready_o=1 once hazard is false.

Verification
REQ-033 Write x5=0xDEADBEEF via WB, then decode instr with rs1=5 -> ex_read_data1_o=0xDEADBEEF one cycle later, ex_valid_o=1.
REQ-034 Write x0=0x1234 while reading rs1=0 -> ex_read_data1_o=0; same-cycle write x7=0x55 with rs2=7 -> ex_read_data2_o=0x55.
REQ-035 Load to rd=3 in EX, next instr uses rs2=3 -> hazard_stall_o=1, id_ready_o=0 one cycle, bubble inserted, then instr issues.
REQ-036 ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> all ex_* outputs unchanged, id_ready_o=0; release -> next instr loads.
REQ-037 flush_i=1 with valid held and id_valid_i=1 -> id_ready_o=1, ex_valid_o=0 next cycle.
REQ-038 Assert rst_i asynchronously between edges -> ex_valid_o=0 and x1..x31 read 0 immediately.
